// File: rtl/rtr_opc_credit_tracker_pkg.sv
// Shared router definitions: VC state encodings and per-class flag layout.
package rtr_opc_credit_tracker_pkg;

    typedef enum logic [1:0] {
        VcIdle   = 2'd0,
        VcActive = 2'd1,
        VcDrain  = 2'd2
    } vc_state_e;

    localparam int unsigned flags_per_class   = 2;
    localparam int unsigned flag_credit_avail = 0;
    localparam int unsigned flag_vc_free      = 1;

    // Position of one flag of packet class pc within a flags_opc vector.
    function automatic int flag_idx(input int pc, input int offset);
        return pc * int'(flags_per_class) + offset;
    endfunction

endpackage

// File: rtl/rtr_opc_credit_tracker_if.sv
// Event inputs and status outputs of one output port's credit tracker.
interface rtr_opc_credit_tracker_if #(
    parameter int unsigned num_packet_classes = 4
);
    logic [0:num_packet_classes-1]   alloc_opc;
    logic [0:num_packet_classes-1]   debit_opc;
    logic [0:num_packet_classes-1]   tail_opc;
    logic [0:num_packet_classes-1]   cred_opc;
    logic [0:num_packet_classes*2-1] flags_opc;
    logic                            error;

    modport master (
        output alloc_opc,
        output debit_opc,
        output tail_opc,
        output cred_opc,
        input  flags_opc,
        input  error
    );

    modport slave (
        input  alloc_opc,
        input  debit_opc,
        input  tail_opc,
        input  cred_opc,
        output flags_opc,
        output error
    );
endinterface

// File: rtl/rtr_opc_credit_ctrl.sv
// One packet class: credit counter, output-VC state machine and, with
// RTR_CREDIT_CHECK_EN defined, a sticky protocol-violation bit.
module rtr_opc_credit_ctrl
    import rtr_opc_credit_tracker_pkg::*;
#(
    parameter int unsigned buffer_size = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic alloc,
    input  logic debit,
    input  logic tail,
    input  logic cred,
    output logic credit_avail,
    output logic vc_free,
    output logic err
);
    localparam int unsigned cred_width = $clog2(buffer_size + 1);
    localparam logic [cred_width-1:0] cnt_full = cred_width'(buffer_size);
    localparam logic [cred_width-1:0] cnt_one  = cred_width'(1);

    logic [cred_width-1:0] cnt_q, cnt_d;
    vc_state_e             state_q, state_d;
    logic                  cnt_d_full;

    // Wraps on violation; the check logic reports it instead of clamping.
    always_comb begin
        cnt_d = cnt_q;
        if (debit && !cred) begin
            cnt_d = cnt_q - cnt_one;
        end else if (cred && !debit) begin
            cnt_d = cnt_q + cnt_one;
        end
        cnt_d_full = (cnt_d == cnt_full);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            VcIdle: begin
                if (alloc) begin
                    if (debit && tail) begin
                        state_d = cnt_d_full ? VcIdle : VcDrain;
                    end else begin
                        state_d = VcActive;
                    end
                end
            end
            VcActive: begin
                if (debit && tail) begin
                    state_d = cnt_d_full ? VcIdle : VcDrain;
                end
            end
            VcDrain: begin
                if (cnt_d_full) begin
                    state_d = VcIdle;
                end
            end
            default: state_d = VcIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= cnt_full;
            state_q <= VcIdle;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign credit_avail = (cnt_q != '0);
    assign vc_free      = (state_q == VcIdle);

`ifdef RTR_CREDIT_CHECK_EN
    logic err_q;
    logic viol;

    always_comb begin
        viol = (debit && !cred && (cnt_q == '0))
             | (cred && !debit && (cnt_q == cnt_full))
             | (alloc && (state_q != VcIdle))
             | (debit && !alloc && (state_q == VcIdle));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | viol;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/rtr_opc_credit_tracker.sv
// Per-output-port credit/VC tracker: one rtr_opc_credit_ctrl per packet class.
// Protocol checking is built in only when RTR_CREDIT_CHECK_EN is defined.
module rtr_opc_credit_tracker
    import rtr_opc_credit_tracker_pkg::*;
#(
    parameter int unsigned num_message_classes  = 2,
    parameter int unsigned num_resource_classes = 2,
    parameter int unsigned buffer_size          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    rtr_opc_credit_tracker_if.slave   bus
);
    localparam int unsigned num_packet_classes = num_message_classes * num_resource_classes;

    logic [0:num_packet_classes-1]                 credit_avail;
    logic [0:num_packet_classes-1]                 vc_free;
    logic [0:num_packet_classes-1]                 err_pc;
    logic [0:num_packet_classes*flags_per_class-1] flags;

    for (genvar pc = 0; pc < num_packet_classes; pc++) begin : g_class
        rtr_opc_credit_ctrl #(
            .buffer_size (buffer_size)
        ) u_ctrl (
            .clk          (clk),
            .reset        (reset),
            .alloc        (bus.alloc_opc[pc]),
            .debit        (bus.debit_opc[pc]),
            .tail         (bus.tail_opc[pc]),
            .cred         (bus.cred_opc[pc]),
            .credit_avail (credit_avail[pc]),
            .vc_free      (vc_free[pc]),
            .err          (err_pc[pc])
        );
    end

    always_comb begin
        flags = '0;
        for (int pc = 0; pc < int'(num_packet_classes); pc++) begin
            flags[flag_idx(pc, int'(flag_credit_avail))] = credit_avail[pc];
            flags[flag_idx(pc, int'(flag_vc_free))]      = vc_free[pc];
        end
    end

    assign bus.flags_opc = flags;
    assign bus.error     = |err_pc;

endmodule

// File: tb/tb_rtr_opc_credit_tracker.sv
// Directed bench for rtr_opc_credit_tracker (4 classes, buffer_size 8).
module tb_rtr_opc_credit_tracker;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rtr_opc_credit_tracker_if #(.num_packet_classes(4)) bus ();

    rtr_opc_credit_tracker #(
        .num_message_classes  (2),
        .num_resource_classes (2),
        .buffer_size          (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RTR_CREDIT_CHECK_EN
    localparam logic exp_ovf_err = 1'b1;
`else
    localparam logic exp_ovf_err = 1'b0;
`endif

    // Class masks: element 0 of the ascending vectors is the MSB.
    localparam logic [0:3] c0 = 4'b1000;
    localparam logic [0:3] c1 = 4'b0100;
    localparam logic [0:3] c2 = 4'b0010;
    localparam logic [0:3] c3 = 4'b0001;
    localparam logic [0:3] none = 4'b0000;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply events for one clock cycle; returns #1 after the edge.
    task automatic cyc(input logic [0:3] a, input logic [0:3] d, input logic [0:3] t,
                       input logic [0:3] c);
        bus.alloc_opc = a;
        bus.debit_opc = d;
        bus.tail_opc  = t;
        bus.cred_opc  = c;
        @(posedge clk);
        #1;
        bus.alloc_opc = '0;
        bus.debit_opc = '0;
        bus.tail_opc  = '0;
        bus.cred_opc  = '0;
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        check_val("rst_async_flags", 32'(bus.flags_opc), 32'hFF);
        check_val("rst_async_err", 32'(bus.error), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.alloc_opc = '0;
        bus.debit_opc = '0;
        bus.tail_opc  = '0;
        bus.cred_opc  = '0;

        // Reset values, then idle after release.
        #2;
        check_val("reset_flags", 32'(bus.flags_opc), 32'hFF);
        check_val("reset_err", 32'(bus.error), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(none, none, none, none);
        check_val("idle_flags", 32'(bus.flags_opc), 32'hFF);
        check_val("idle_err", 32'(bus.error), 32'h0);

        // Class 0: full packet drains all credits, then credits return.
        cyc(c0, none, none, none);
        check_val("c0_alloc", 32'(bus.flags_opc), 32'hBF);
        for (int i = 0; i < 7; i++) cyc(none, c0, none, none);
        check_val("c0_cnt1", 32'(bus.flags_opc), 32'hBF);
        cyc(none, c0, c0, none);
        check_val("c0_empty_drain", 32'(bus.flags_opc), 32'h3F);
        cyc(none, none, none, c0);
        check_val("c0_first_cred", 32'(bus.flags_opc), 32'hBF);
        for (int i = 0; i < 6; i++) cyc(none, none, none, c0);
        check_val("c0_cnt7_drain", 32'(bus.flags_opc), 32'hBF);
        cyc(none, none, none, c0);
        check_val("c0_idle_again", 32'(bus.flags_opc), 32'hFF);

        // Class 2: bring cnt to 3, then debit+cred together holds it.
        cyc(c2, none, none, none);
        check_val("c2_alloc", 32'(bus.flags_opc), 32'hFB);
        for (int i = 0; i < 5; i++) cyc(none, c2, none, none);
        for (int i = 0; i < 5; i++) begin
            cyc(none, c2, none, c2);
            check_val("c2_debit_cred_hold", 32'(bus.flags_opc), 32'hFB);
        end
        cyc(none, c2, c2, none);
        check_val("c2_tail_drain", 32'(bus.flags_opc), 32'hFB);
        for (int i = 0; i < 6; i++) cyc(none, none, none, c2);
        check_val("c2_idle_again", 32'(bus.flags_opc), 32'hFF);

        // Class 1: single-flit packet.
        cyc(c1, c1, c1, none);
        check_val("c1_single_flit", 32'(bus.flags_opc), 32'hEF);
        cyc(none, none, none, c1);
        check_val("c1_cred_idle", 32'(bus.flags_opc), 32'hFF);

        // Concurrent events on classes 0 and 3.
        cyc(c3, none, none, none);
        check_val("c3_alloc", 32'(bus.flags_opc), 32'hFE);
        cyc(c0, c3, none, none);
        check_val("c0c3_concurrent", 32'(bus.flags_opc), 32'hBE);
        check_val("concurrent_err", 32'(bus.error), 32'h0);

        // Reset mid-packet discards all state.
        do_reset();
        check_val("post_reset_flags", 32'(bus.flags_opc), 32'hFF);

        // Credit overflow on class 3.
        cyc(none, none, none, c3);
        check_val("ovf_err", 32'(bus.error), 32'(exp_ovf_err));
        check_val("ovf_flags", 32'(bus.flags_opc), 32'hFF);
        cyc(none, none, none, none);
        cyc(none, none, none, none);
        check_val("ovf_err_sticky", 32'(bus.error), 32'(exp_ovf_err));
        do_reset();
        check_val("err_cleared", 32'(bus.error), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
